// File: rtl/int_seq.sv
// Reset/NMI/IRQ sequencer for the m6502 core.
// At an instruction boundary it takes over the program counter. It pushes
// PCH, PCL and P, loads the vector address, fetches the two vector bytes and
// then jumps. prog_ctl is all-zero whenever busy=0, so it can be ORed with
// the main decoder's control word.
//
// Handshake: rdy=1 advances the sequencer by one state per clock. rdy=0
// freezes state and kind, and suppresses every pulse output (prog_ctl,
// push_sel, set_i, int_done). busy keeps its value. The NMI edge detector
// keeps sampling while rdy=0.
module int_seq #(
  parameter logic [1:0] VEC_NMI = 2'b01,
  parameter logic [1:0] VEC_RST = 2'b10,
  parameter logic [1:0] VEC_IRQ = 2'b11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rdy,
  input  logic       sync,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       i_flag,
  output logic [6:0] prog_ctl,
  output logic [1:0] push_sel,
  output logic       busy,
  output logic       set_i,
  output logic       int_done,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PUSH_H  = 3'd1,
    S_PUSH_L  = 3'd2,
    S_PUSH_P  = 3'd3,
    S_VEC     = 3'd4,
    S_FETCH_L = 3'd5,
    S_FETCH_H = 3'd6
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       kind_rst;  // 1 while the running sequence is the reset sequence
  logic       nmi_pend;
  logic       nmi_q;
  logic       nmi_edge;
  logic       irq_req;
  logic       take_nmi;
  logic       accept;
  logic [1:0] vec_sel;

  assign nmi_edge  = nmi_q & ~nmi_n;
  assign irq_req   = ~irq_n & ~i_flag;
  assign accept    = rdy & (state == S_IDLE) & (state_nxt == S_PUSH_H);
  assign dbg_state = state;

  // The vector is resolved in VEC, not at acceptance. An NMI that arrives
  // during the pushes therefore hijacks an IRQ sequence.
  assign vec_sel  = kind_rst ? VEC_RST : (nmi_pend ? VEC_NMI : VEC_IRQ);
  assign take_nmi = rdy & (state == S_VEC) & ~kind_rst & nmi_pend;

  // State register: reset parks in VEC so the reset vector loads first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_VEC;
    end else if (rdy) begin
      state <= state_nxt;
    end
  end

  // Kind and NMI bookkeeping. A new edge wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      kind_rst <= 1'b1;
      nmi_pend <= 1'b0;
      nmi_q    <= 1'b1;
    end else begin
      nmi_q    <= nmi_n;
      nmi_pend <= nmi_edge | (nmi_pend & ~take_nmi);
      if (accept) begin
        kind_rst <= 1'b0;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (sync && (nmi_pend || irq_req)) state_nxt = S_PUSH_H;
      S_PUSH_H:  state_nxt = S_PUSH_L;
      S_PUSH_L:  state_nxt = S_PUSH_P;
      S_PUSH_P:  state_nxt = S_VEC;
      S_VEC:     state_nxt = S_FETCH_L;
      S_FETCH_L: state_nxt = S_FETCH_H;
      S_FETCH_H: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output decode. All outputs are gated off during reset and stalls.
  always_comb begin
    prog_ctl = 7'h00;
    push_sel = 2'b00;
    set_i    = 1'b0;
    int_done = 1'b0;
    busy     = reset | (state != S_IDLE);
    if (!reset && rdy) begin
      case (state)
        S_PUSH_H:  push_sel = 2'b01;
        S_PUSH_L:  push_sel = 2'b10;
        S_PUSH_P:  push_sel = 2'b11;
        S_VEC:     prog_ctl = {vec_sel, 5'b00100};
        S_FETCH_L: prog_ctl = 7'h0B;
        S_FETCH_H: begin
          prog_ctl = 7'h0C;
          set_i    = 1'b1;
          int_done = 1'b1;
        end
        default:   prog_ctl = 7'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_int_seq.sv
// Testbench for int_seq: directed scenarios followed by randomized traffic.
// Outputs are checked each cycle against a sequence-position reference model.
// A small program-counter emulator runs on the observed prog_ctl. It checks
// that every completed sequence lands on the correct vector contents.
module tb_int_seq;

  logic       clk = 1'b0;
  logic       reset, rdy, sync, nmi_n, irq_n, i_flag;
  logic [6:0] prog_ctl;
  logic [1:0] push_sel;
  logic       busy, set_i, int_done;
  logic [2:0] dbg_state;

  int compared = 0;
  int mismatched = 0;

  int_seq dut (
    .clk(clk), .reset(reset), .rdy(rdy), .sync(sync), .nmi_n(nmi_n),
    .irq_n(irq_n), .i_flag(i_flag), .prog_ctl(prog_ctl), .push_sel(push_sel),
    .busy(busy), .set_i(set_i), .int_done(int_done), .dbg_state(dbg_state)
  );

  // Clock: period 10.
  always #5 clk = ~clk;

  // Reference model state. m_pos is the step within a sequence: -1 means
  // idle, 0..2 are the pushes, 3 is the vector load, 4 and 5 are the fetches.
  int          m_pos;
  bit          m_rst;
  bit          m_pend;
  bit          m_nq;
  logic [15:0] exp_q[$];

  // PC emulator driven by the observed prog_ctl.
  logic [15:0] pc;
  logic [7:0]  h;
  logic [6:0]  ctl_seen;

  function automatic logic [7:0] rd(input logic [15:0] a);
    case (a)
      16'hFFFA: rd = 8'h78;
      16'hFFFB: rd = 8'h56;
      16'hFFFC: rd = 8'h34;
      16'hFFFD: rd = 8'h12;
      16'hFFFE: rd = 8'hBC;
      16'hFFFF: rd = 8'h9A;
      default:  rd = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs, advance the model at the edge, then hand back
  // 1 time unit after the edge so the caller can set the next inputs.
  task automatic tick();
    logic [6:0] e_ctl;
    logic [1:0] e_push;
    logic       e_busy, e_pulse;
    logic [1:0] v;
    bit         edge_seen;
    #2;
    v       = m_rst ? 2'b10 : (m_pend ? 2'b01 : 2'b11);
    e_ctl   = 7'h00;
    e_push  = 2'b00;
    e_pulse = 1'b0;
    e_busy  = reset || (m_pos >= 0);
    if (!reset && rdy) begin
      if (m_pos >= 0 && m_pos <= 2) e_push = 2'(m_pos + 1);
      if (m_pos == 3) e_ctl = {v, 5'b00100};
      if (m_pos == 4) e_ctl = 7'h0B;
      if (m_pos == 5) begin
        e_ctl   = 7'h0C;
        e_pulse = 1'b1;
      end
    end
    chk("prog_ctl", 16'(prog_ctl), 16'(e_ctl));
    chk("push_sel", 16'(push_sel), 16'(e_push));
    chk("busy", 16'(busy), 16'(e_busy));
    chk("set_i", 16'(set_i), 16'(e_pulse));
    chk("int_done", 16'(int_done), 16'(e_pulse));
    ctl_seen = prog_ctl;
    @(posedge clk);
    // PC emulator, acting like prog_cnt on the control word of this cycle.
    if (!reset) begin
      if (ctl_seen[1]) h = rd(pc);
      if (ctl_seen[2] && !ctl_seen[3]) pc = 16'hFFF8 + 16'({ctl_seen[6:5], 1'b0});
      else if (ctl_seen[2] && ctl_seen[3]) pc = {rd(pc), h};
      if (ctl_seen[0]) pc = pc + 16'd1;
    end
    // Model update.
    edge_seen = m_nq && !nmi_n;
    if (reset) begin
      m_pos  = 3;
      m_rst  = 1'b1;
      m_pend = 1'b0;
      m_nq   = 1'b1;
      exp_q.delete();
    end else begin
      m_nq = nmi_n;
      if (rdy) begin
        if (m_pos < 0) begin
          if (sync && (m_pend || (!irq_n && !i_flag))) begin
            m_pos = 0;
            m_rst = 1'b0;
          end
        end else if (m_pos == 3) begin
          exp_q.push_back(v == 2'b10 ? 16'h1234 : (v == 2'b01 ? 16'h5678 : 16'h9ABC));
          if (!m_rst && m_pend) m_pend = 1'b0;
          m_pos = 4;
        end else if (m_pos == 5) begin
          if (exp_q.size() == 0) chk("vec_queue_empty", 16'd1, 16'd0);
          else chk("jump_pc", pc, exp_q.pop_front());
          m_pos = -1;
        end else begin
          m_pos = m_pos + 1;
        end
      end
      if (edge_seen) m_pend = 1'b1;
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Accept an IRQ at an instruction boundary, then drop the request.
  task automatic irq_accept();
    i_flag = 1'b0; irq_n = 1'b0; sync = 1'b1;
    tick();
    irq_n = 1'b1; sync = 1'b0;
  endtask

  initial begin
    m_pos = -1; m_rst = 1'b1; m_pend = 1'b0; m_nq = 1'b1;
    pc = 16'h0000; h = 8'h00; ctl_seen = 7'h00;
    reset = 1'b1; rdy = 1'b1; sync = 1'b0; nmi_n = 1'b1; irq_n = 1'b1; i_flag = 1'b1;

    // Reset for 3 cycles, then the reset sequence jumps to 1234.
    run(3);
    reset = 1'b0;
    run(5);
    chk("pc_after_reset", pc, 16'h1234);

    // Plain IRQ sequence.
    irq_accept();
    run(8);

    // Masked IRQ never starts a sequence.
    i_flag = 1'b1; irq_n = 1'b0; sync = 1'b1;
    run(10);
    irq_n = 1'b1; sync = 1'b0;

    // NMI edge during PUSH_L hijacks the IRQ. The pending NMI is then
    // consumed, so a later boundary stays idle.
    irq_accept();
    tick();
    nmi_n = 1'b0;
    run(6);
    sync = 1'b1;
    run(3);
    nmi_n = 1'b1; sync = 1'b0;
    run(2);

    // Stall for two cycles in FETCH_L.
    irq_accept();
    run(4);
    rdy = 1'b0;
    run(2);
    rdy = 1'b1;
    run(4);

    // Reset asserted in PUSH_P aborts into the reset sequence.
    irq_accept();
    run(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run(5);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rdy    = ($urandom_range(0, 7) != 0);
      sync   = ($urandom_range(0, 2) == 0);
      irq_n  = ($urandom_range(0, 3) != 0);
      i_flag = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) nmi_n = ~nmi_n;
      reset  = ($urandom_range(0, 249) == 0);
      tick();
    end
    reset = 1'b0; rdy = 1'b1; sync = 1'b0; irq_n = 1'b1; nmi_n = 1'b1;
    run(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
